// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division. Both run on
// operand magnitudes, one bit per cycle, and the result signs are fixed up
// in a single FINISH cycle before HI/LO are committed.
module mult_div_unit #(
    parameter int size = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [size-1:0] src1_i,
    input  logic [size-1:0] src2_i,
    input  logic            hi_we_i,
    input  logic            lo_we_i,
    input  logic [size-1:0] wdata_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [size-1:0] hi_o,
    output logic [size-1:0] lo_o
);

    localparam int CW = (size > 1) ? $clog2(size) : 1;
    localparam logic [CW-1:0] LAST = CW'(size - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_t;

    state_t state, state_next;

    logic              is_div;
    logic              neg_res;
    logic              neg_rem;
    logic              div_zero;
    logic [size-1:0]   a_mag;
    logic [size-1:0]   b_mag;
    logic [2*size-1:0] acc;
    logic [CW-1:0]     count;
    logic              done_q;
    logic [size-1:0]   hi_q;
    logic [size-1:0]   lo_q;

    // Operand magnitudes and sign flags, taken at the accept edge
    logic              sign1;
    logic              sign2;
    logic [size-1:0]   abs1;
    logic [size-1:0]   abs2;

    // One iteration of each algorithm, plus the sign-corrected results
    logic [size:0]     add_sum;
    logic [2*size-1:0] mul_next;
    logic [size:0]     shifted;
    logic [size+1:0]   diff;
    logic [2*size-1:0] div_next;
    logic [2*size-1:0] prod_fix;
    logic [size-1:0]   quo_fix;
    logic [size-1:0]   rem_fix;

    // Sign detection and absolute values for the signed operations
    always_comb begin
        sign1 = op_i[0] & src1_i[size-1];
        sign2 = op_i[0] & src2_i[size-1];
        abs1  = sign1 ? (~src1_i + 1'b1) : src1_i;
        abs2  = sign2 ? (~src2_i + 1'b1) : src2_i;
    end

    // Single step of shift-add multiply and restoring divide, and the commit values
    always_comb begin
        add_sum  = {1'b0, acc[2*size-1:size]} + {1'b0, a_mag};
        mul_next = acc[0] ? {add_sum, acc[size-1:1]}
                          : {1'b0, acc[2*size-1:1]};

        shifted  = {acc[2*size-1:size], acc[size-1]};
        diff     = {1'b0, shifted} - {2'b00, b_mag};
        div_next = diff[size+1] ? {shifted[size-1:0], acc[size-2:0], 1'b0}
                                : {diff[size-1:0],    acc[size-2:0], 1'b1};

        prod_fix = neg_res ? (~acc + 1'b1) : acc;
        if (div_zero) begin
            quo_fix = '1;
        end else begin
            quo_fix = neg_res ? (~acc[size-1:0] + 1'b1) : acc[size-1:0];
        end
        rem_fix = neg_rem ? (~acc[2*size-1:size] + 1'b1) : acc[2*size-1:size];
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> CALC on start, size CALC cycles, one FINISH cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = CALC;
            CALC:    if (count == LAST) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, commit and MTHI/MTLO writes
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            a_mag    <= '0;
            b_mag    <= '0;
            acc      <= '0;
            count    <= '0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we_i) hi_q <= wdata_i;
                    if (lo_we_i) lo_q <= wdata_i;
                    if (start_i) begin
                        is_div   <= op_i[1];
                        neg_res  <= sign1 ^ sign2;
                        neg_rem  <= sign1;
                        div_zero <= op_i[1] & (src2_i == '0);
                        a_mag    <= abs1;
                        b_mag    <= abs2;
                        acc      <= op_i[1] ? {{size{1'b0}}, abs1} : {{size{1'b0}}, abs2};
                        count    <= '0;
                    end
                end
                CALC: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= count + 1'b1;
                end
                FINISH: begin
                    if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*size-1:size];
                        lo_q <= prod_fix[size-1:0];
                    end
                    done_q <= 1'b1;
                    count  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy_o = (state != IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a table of operations with hand-computed
// HI/LO results, followed by sequences for start-while-busy, mid-operation
// reset and MTHI/MTLO handling.
module tb_mult_div_unit;

    localparam logic [1:0] MULTU = 2'b00;
    localparam logic [1:0] MULT  = 2'b01;
    localparam logic [1:0] DIVU  = 2'b10;
    localparam logic [1:0] DIV   = 2'b11;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic        hi_we_i;
    logic        lo_we_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];

    mult_div_unit #(.size(32)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .op_i    (op_i),
        .src1_i  (src1_i),
        .src2_i  (src2_i),
        .hi_we_i (hi_we_i),
        .lo_we_i (lo_we_i),
        .wdata_i (wdata_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    // 10 ns clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Compare one value and report it if it differs
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Launch one operation, scramble the operand inputs after the accept edge,
    // and wait (bounded) for done, measuring latency and busy cycles
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output int lat, output int busy_cnt);
        @(negedge clk_i);
        start_i = 1'b1;
        op_i    = op;
        src1_i  = a;
        src2_i  = b;
        @(posedge clk_i);
        #1;
        start_i  = 1'b0;
        op_i     = ~op;
        src1_i   = $urandom;
        src2_i   = $urandom;
        lat      = 0;
        busy_cnt = 0;
        while (!done_o && lat < 100) begin
            if (busy_o) busy_cnt++;
            @(posedge clk_i);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int busy_cnt;
        int done_cnt;

        vecs[0]  = '{"multu_max",   MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{"mult_m3x5",   MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{"mult_minmin", MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3]  = '{"divu_100_7",  DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[4]  = '{"div_m7_2",    DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[5]  = '{"div_min_m1",  DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{"divu_by0",    DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
        vecs[7]  = '{"div_by0",     DIV,   32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF};
        vecs[8]  = '{"multu_shift", MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[9]  = '{"div_7_m2",    DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{"divu_max_1",  DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
        vecs[11] = '{"mult_m1xm1",  MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

        rst_i   = 1'b0;
        start_i = 1'b0;
        op_i    = 2'b00;
        src1_i  = '0;
        src2_i  = '0;
        hi_we_i = 1'b0;
        lo_we_i = 1'b0;
        wdata_i = '0;

        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("reset_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("reset_done", {31'd0, done_o}, 32'd0);
        checkOutput("reset_hi", hi_o, 32'd0);
        checkOutput("reset_lo", lo_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Table-driven operations, issued back to back
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_cnt);
            checkOutput({vecs[i].name, "_latency"}, lat, 32'd33);
            checkOutput({vecs[i].name, "_busy"}, busy_cnt, 32'd33);
            checkOutput({vecs[i].name, "_hi"}, hi_o, vecs[i].hi);
            checkOutput({vecs[i].name, "_lo"}, lo_o, vecs[i].lo);
        end
        @(posedge clk_i);
        #1;
        checkOutput("done_one_cycle", {31'd0, done_o}, 32'd0);

        // Start pulsed while busy must be ignored
        @(negedge clk_i);
        start_i = 1'b1; op_i = DIVU; src1_i = 32'd100; src2_i = 32'd7;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        start_i = 1'b1; op_i = MULTU; src1_i = 32'd2; src2_i = 32'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk_i);
            #1;
            if (done_o) done_cnt++;
        end
        checkOutput("busy_start_done_cnt", done_cnt, 32'd1);
        checkOutput("busy_start_hi", hi_o, 32'd2);
        checkOutput("busy_start_lo", lo_o, 32'd14);

        // Reset in the middle of an operation
        @(negedge clk_i);
        start_i = 1'b1; op_i = MULTU; src1_i = 32'hFFFF; src2_i = 32'hFFFF;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        checkOutput("midrst_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("midrst_hi", hi_o, 32'd0);
        checkOutput("midrst_lo", lo_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk_i);
            #1;
            if (done_o) done_cnt++;
        end
        checkOutput("midrst_no_done", done_cnt, 32'd0);
        applyStimulus(MULTU, 32'd6, 32'd7, lat, busy_cnt);
        checkOutput("post_rst_latency", lat, 32'd33);
        checkOutput("post_rst_hi", hi_o, 32'd0);
        checkOutput("post_rst_lo", lo_o, 32'd42);

        // MTHI/MTLO in IDLE, together and individually
        @(negedge clk_i);
        hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'hDEADBEEF;
        @(posedge clk_i);
        #1;
        hi_we_i = 1'b0; lo_we_i = 1'b0;
        checkOutput("mt_both_hi", hi_o, 32'hDEADBEEF);
        checkOutput("mt_both_lo", lo_o, 32'hDEADBEEF);
        @(negedge clk_i);
        lo_we_i = 1'b1; wdata_i = 32'h0BADF00D;
        @(posedge clk_i);
        #1;
        lo_we_i = 1'b0;
        checkOutput("mtlo_only_hi", hi_o, 32'hDEADBEEF);
        checkOutput("mtlo_only_lo", lo_o, 32'h0BADF00D);

        // Writes while busy are ignored until the commit
        @(negedge clk_i);
        start_i = 1'b1; op_i = MULTU; src1_i = 32'd6; src2_i = 32'd7;
        @(negedge clk_i);
        start_i = 1'b0;
        hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'h12345678;
        repeat (5) @(negedge clk_i);
        hi_we_i = 1'b0; lo_we_i = 1'b0;
        checkOutput("busy_wr_hi", hi_o, 32'hDEADBEEF);
        checkOutput("busy_wr_lo", lo_o, 32'h0BADF00D);
        lat = 0;
        while (!done_o && lat < 100) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        checkOutput("busy_wr_timeout", {31'd0, done_o}, 32'd1);
        checkOutput("busy_wr_commit_hi", hi_o, 32'd0);
        checkOutput("busy_wr_commit_lo", lo_o, 32'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the pipelined MIPS datapath, sitting in the EX stage beside the ALU. It computes MULT, MULTU, DIV and DIVU over `size` cycles and holds the results in architectural HI/LO registers. `hi_o`/`lo_o` drive data inputs of the writeback-select 4-to-1 multiplexer for MFHI/MFLO. The hazard unit stalls on `busy_o`.

## Interface
- `size`, default 32: operand width; HI and LO are each `size` bits wide.
- `clk_i`: input, 1 bit; rising-edge clock.
- `rst_i`: input, 1 bit; asynchronous, active-low reset.
- `start_i`: input, 1 bit; launches an operation; sampled only in IDLE.
- `op_i`: input, 2 bits; 00 MULTU, 01 MULT, 10 DIVU, 11 DIV; latched on start.
- `src1_i`: input, `size` bits; multiplicand or dividend (rs); latched on start.
- `src2_i`: input, `size` bits; multiplier or divisor (rt); latched on start.
- `hi_we_i`: input, 1 bit; MTHI write enable.
- `lo_we_i`: input, 1 bit; MTLO write enable.
- `wdata_i`: input, `size` bits; MTHI/MTLO write data.
- `busy_o`: output, 1 bit; high while an operation is in flight.
- `done_o`: output, 1 bit; one-cycle pulse when HI/LO take a new result.
- `hi_o`: output, `size` bits; HI register (product high half / remainder).
- `lo_o`: output, `size` bits; LO register (product low half / quotient).

## Operation
- States:
  - IDLE: `busy_o=0`.
  - CALC: `busy_o=1`; cycle counter runs 0..`size`-1.
  - FINISH: `busy_o=1`; sign fix-up, then commit.
- IDLE -> CALC when `start_i=1`. At that edge:
  - latch `op_i`;
  - for signed ops, latch the absolute values of the operands plus the sign flags;
  - clear the accumulator and the counter.
- CALC, multiply: shift-add, one multiplier bit per cycle, into a 2×`size` accumulator.
- CALC, divide: restoring division, one quotient bit per cycle. Compare with (`size`+1)-bit subtract; never truncate the partial remainder.
- CALC -> FINISH after the counter reaches `size`-1.
- FINISH, one cycle, then -> IDLE. At the commit edge:
  - MULT: negate the 2×`size` product if the operand signs differ.
  - DIV: negate the quotient if the signs differ. Negate the remainder if the dividend is negative. This gives truncation toward zero, with the remainder taking the dividend's sign.
  - Write {HI,LO} = product, or HI = remainder and LO = quotient.
  - Register `done_o=1` for exactly one cycle.
- Divide by zero, signed or unsigned: HI = original `src1_i`, LO = all ones. No trap.
- DIV of the most-negative value by -1: LO = most-negative value (wraps), HI = 0. This falls out of the magnitude algorithm and must not be special-cased differently.
- MTHI/MTLO: in IDLE, `hi_we_i`/`lo_we_i` write `wdata_i` to HI/LO at the next edge. Both may be asserted together.
- Writes while `busy_o=1` are ignored. The pipeline is stalled then, so none should occur.
- `start_i` while busy is ignored. It is not queued.
- `start_i` and a write in the same IDLE cycle: the write lands, and the operation's commit later overwrites the affected registers.
- Operand and `op_i` changes after the accept edge have no effect.
- Reset (asynchronous, `rst_i=0`), including mid-operation:
  - state goes to IDLE;
  - `busy_o=0`, `done_o=0`, `hi_o=0`, `lo_o=0`;
  - counter and accumulator are cleared;
  - the in-flight operation is discarded with no `done_o`.

## Timing
- Accept edge E0, with `start_i=1` in IDLE. `busy_o` is 1 from E0 until E(`size`+1).
- Commit edge E(`size`+1): HI/LO update and `done_o` rises; `busy_o` falls at the same edge.
- Total latency is `size`+1 edges, 33 for `size`=32.
- `done_o` is high for exactly one cycle, E(`size`+1) to E(`size`+2).
- A new `start_i` is accepted as early as edge E(`size`+2), i.e. sampled in the cycle `done_o` is high. Back-to-back throughput is therefore one operation per `size`+2 cycles.
- `hi_o`/`lo_o` are registered outputs. They are stable except at the commit edge or an MTHI/MTLO edge.
- The MFHI/MFLO path through the downstream multiplexer sees new values the cycle after commit.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, `done_o` exactly 33 edges after accept, `busy_o` high for 33 cycles.
- MULT -3 × 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
- DIVU 100 / 7 -> LO=14, HI=2.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x1234 / 0 -> HI=0x1234, LO=0xFFFFFFFF.
- DIV 0xFFFFFFF0 / 0 -> HI=0xFFFFFFF0, LO=0xFFFFFFFF.
- Start DIVU 100/7, then pulse `start_i` with MULTU 2×3 at cycle 5 -> second start ignored; final LO=14, HI=2; a single `done_o` pulse.
- Start MULTU, assert `rst_i=0` at cycle 10 -> `busy_o`, `hi_o`, `lo_o` go to 0 immediately and no `done_o` fires. Release reset, then MULTU 6×7 -> LO=42, HI=0.
- In IDLE, `hi_we_i=1`/`lo_we_i=1` with `wdata_i`=0xDEADBEEF -> HI=LO=0xDEADBEEF next cycle.
- Same write while busy -> HI/LO unchanged until commit.
